fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues in-order imem requests, parks responses in a small
// in-order queue for decode, and squashes in-flight fetches on control-flow redirects.
module fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        jump_target,
  input  logic        jump_branch,
  input  logic        jump_reg,
  input  logic [31:0] pc_id,
  input  logic [25:0] instr_id,
  input  logic [31:0] jr_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

  logic [31:0]   r_fetch_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW-1:0] r_fill;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_slot_pc    [DEPTH];
  logic [31:0]   r_slot_instr [DEPTH];
  logic [DEPTH-1:0] r_slot_filled;

  logic          w_redirect;
  logic [31:0]   w_pc_id_p4;
  logic [31:0]   w_branch_off;
  logic [31:0]   w_target;
  logic [CW-1:0] w_pending;
  logic          w_resp_drop;
  logic          w_resp_fill;
  logic          w_resp_take;
  logic          w_req_valid;
  logic          w_if_valid;
  logic          w_issue;
  logic          w_pop;

  assign w_redirect   = jump_reg | jump_target | jump_branch;
  assign w_pc_id_p4   = pc_id + 32'd4;
  assign w_branch_off = {{14{instr_id[15]}}, instr_id[15:0], 2'b00};

  always_comb begin
    w_target = w_pc_id_p4 + w_branch_off;
    if (jump_reg)
      w_target = jr_addr;
    else if (jump_target)
      w_target = {w_pc_id_p4[31:28], instr_id, 2'b00};
  end

  // Slots between r_fill and r_tail still await data; anything beyond that in flight is stale.
  assign w_pending   = r_outstanding - r_drop;
  assign w_resp_drop = imem_resp_valid & (r_drop != '0);
  assign w_resp_fill = imem_resp_valid & (r_drop == '0) & (w_pending != '0);
  assign w_resp_take = w_resp_drop | w_resp_fill;

  assign w_req_valid = rst & en & ~w_redirect & (r_outstanding < MAX_C) & (r_count < DEPTH_C);
  assign w_if_valid  = en & ~w_redirect & r_slot_filled[r_head];
  assign w_issue     = w_req_valid & imem_req_ready;
  assign w_pop       = w_if_valid & if_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign if_valid       = w_if_valid;
  assign if_pc          = r_slot_pc[r_head];
  assign if_instr       = r_slot_instr[r_head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_fill        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_slot_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_slot_pc[i]    <= '0;
        r_slot_instr[i] <= '0;
      end
    end else if (w_redirect) begin
      // Every request still in flight belongs to the squashed path and must be discarded.
      r_fetch_pc    <= w_target;
      r_head        <= '0;
      r_tail        <= '0;
      r_fill        <= '0;
      r_count       <= '0;
      r_slot_filled <= '0;
      r_outstanding <= r_outstanding - CW'(w_resp_take);
      r_drop        <= r_outstanding - CW'(w_resp_take);
    end else begin
      if (w_issue) begin
        r_fetch_pc               <= r_fetch_pc + 32'd4;
        r_tail                   <= r_tail + AW'(1);
        r_slot_pc[r_tail]        <= r_fetch_pc;
        r_slot_filled[r_tail]    <= 1'b0;
      end
      if (w_pop) begin
        r_head                   <= r_head + AW'(1);
        r_slot_filled[r_head]    <= 1'b0;
      end
      if (w_resp_fill) begin
        r_fill                   <= r_fill + AW'(1);
        r_slot_instr[r_fill]     <= imem_resp_data;
        r_slot_filled[r_fill]    <= 1'b1;
      end
      if (w_resp_drop)
        r_drop <= r_drop - CW'(1);
      r_count       <= r_count + CW'(w_issue) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_resp_take);
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    imem_resp_valid |-> ((r_drop != '0) || (w_pending != '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue: streaming, back-pressure, redirects,
// enable gating and asynchronous reset in the middle of a stream.
module tb_fetch_queue;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        jumpTarget = 1'b0;
  logic        jumpBranch = 1'b0;
  logic        jumpReg = 1'b0;
  logic [31:0] pcId = '0;
  logic [25:0] instrId = '0;
  logic [31:0] jrAddr = '0;
  logic        reqValid;
  logic        reqReady = 1'b0;
  logic [31:0] reqAddr;
  logic        respValid = 1'b0;
  logic [31:0] respData = '0;
  logic        ifValid;
  logic        ifReady = 1'b0;
  logic [31:0] ifPc;
  logic [31:0] ifInstr;

  int checks = 0;
  int fails = 0;

  fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .jump_target(jumpTarget), .jump_branch(jumpBranch), .jump_reg(jumpReg),
    .pc_id(pcId), .instr_id(instrId), .jr_addr(jrAddr),
    .imem_req_valid(reqValid), .imem_req_ready(reqReady), .imem_req_addr(reqAddr),
    .imem_resp_valid(respValid), .imem_resp_data(respData),
    .if_valid(ifValid), .if_ready(ifReady), .if_pc(ifPc), .if_instr(ifInstr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        doReset;
    logic        en;
    logic [2:0]  redir;
    logic [31:0] pcId;
    logic [25:0] instrId;
    logic [31:0] jrAddr;
    logic        reqReady;
    logic        respValid;
    logic [31:0] respData;
    logic        ifReady;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expIfValid;
    logic [31:0] expIfPc;
    logic [31:0] expIfInstr;
  } vec_t;

  vec_t vecs[$];

  // redir is {jump_reg, jump_target, jump_branch}
  function automatic vec_t mk(string name, logic doReset, logic e, logic [2:0] redir,
                              logic [31:0] pc, logic [25:0] ins, logic [31:0] jr,
                              logic rdy, logic rv, logic [31:0] rd, logic ir,
                              logic eRqv, logic [31:0] eAddr, logic eIfv,
                              logic [31:0] ePc, logic [31:0] eInstr);
    vec_t v;
    v.name = name; v.doReset = doReset; v.en = e; v.redir = redir;
    v.pcId = pc; v.instrId = ins; v.jrAddr = jr;
    v.reqReady = rdy; v.respValid = rv; v.respData = rd; v.ifReady = ir;
    v.expReqValid = eRqv; v.expReqAddr = eAddr; v.expIfValid = eIfv;
    v.expIfPc = ePc; v.expIfInstr = eInstr;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  task automatic driveIdle();
    en = 1'b0; jumpTarget = 1'b0; jumpBranch = 1'b0; jumpReg = 1'b0;
    pcId = '0; instrId = '0; jrAddr = '0;
    reqReady = 1'b0; respValid = 1'b0; respData = '0; ifReady = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b0;
    driveIdle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic applyStimulus(vec_t v);
    if (v.doReset) resetDut();
    else @(negedge clk);
    en = v.en;
    jumpReg = v.redir[2]; jumpTarget = v.redir[1]; jumpBranch = v.redir[0];
    pcId = v.pcId; instrId = v.instrId; jrAddr = v.jrAddr;
    reqReady = v.reqReady; respValid = v.respValid; respData = v.respData;
    ifReady = v.ifReady;
    #1;
    checkOutput({v.name, " req_valid"}, 32'(reqValid), 32'(v.expReqValid));
    if (v.expReqValid) checkOutput({v.name, " req_addr"}, reqAddr, v.expReqAddr);
    checkOutput({v.name, " if_valid"}, 32'(ifValid), 32'(v.expIfValid));
    if (v.expIfValid) begin
      checkOutput({v.name, " if_pc"}, ifPc, v.expIfPc);
      checkOutput({v.name, " if_instr"}, ifInstr, v.expIfInstr);
    end
  endtask

  initial begin
    // Streaming with single-cycle memory latency
    vecs.push_back(mk("A0", H, H, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         H, H, 32'h0,  L, 32'h0, 32'h0));
    vecs.push_back(mk("A1", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_0000, H, H, 32'h4,  L, 32'h0, 32'h0));
    vecs.push_back(mk("A2", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_0004, H, H, 32'h8,  H, 32'h0, 32'hA000_0000));
    vecs.push_back(mk("A3", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_0008, H, H, 32'hC,  H, 32'h4, 32'hA000_0004));
    vecs.push_back(mk("A4", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_000C, H, H, 32'h10, H, 32'h8, 32'hA000_0008));
    // Decode stalled: queue fills to DEPTH, then one pop frees one slot
    vecs.push_back(mk("B0", H, H, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         L, H, 32'h0,  L, 32'h0, 32'h0));
    vecs.push_back(mk("B1", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_0000, L, H, 32'h4,  L, 32'h0, 32'h0));
    vecs.push_back(mk("B2", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_0004, L, H, 32'h8,  H, 32'h0, 32'hA000_0000));
    vecs.push_back(mk("B3", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_0008, L, H, 32'hC,  H, 32'h0, 32'hA000_0000));
    vecs.push_back(mk("B4", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_000C, L, L, 32'h0,  H, 32'h0, 32'hA000_0000));
    vecs.push_back(mk("B5", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         L, L, 32'h0,  H, 32'h0, 32'hA000_0000));
    vecs.push_back(mk("B6", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         H, L, 32'h0,  H, 32'h0, 32'hA000_0000));
    vecs.push_back(mk("B7", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         L, H, 32'h10, H, 32'h4, 32'hA000_0004));
    vecs.push_back(mk("B8", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_0010, L, L, 32'h0,  H, 32'h4, 32'hA000_0004));
    // Jump with two requests in flight; both stale responses must vanish
    vecs.push_back(mk("C0", H, H, 3'b000, 32'h0,   26'h0,  32'h0, H, L, 32'h0,         L, H, 32'h0,   L, 32'h0,   32'h0));
    vecs.push_back(mk("C1", L, H, 3'b000, 32'h0,   26'h0,  32'h0, H, L, 32'h0,         L, H, 32'h4,   L, 32'h0,   32'h0));
    vecs.push_back(mk("C2", L, H, 3'b010, 32'h100, 26'h40, 32'h0, H, L, 32'h0,         L, L, 32'h0,   L, 32'h0,   32'h0));
    vecs.push_back(mk("C3", L, H, 3'b000, 32'h0,   26'h0,  32'h0, H, H, 32'hDEAD_0000, L, L, 32'h0,   L, 32'h0,   32'h0));
    vecs.push_back(mk("C4", L, H, 3'b000, 32'h0,   26'h0,  32'h0, H, H, 32'hDEAD_0004, L, H, 32'h100, L, 32'h0,   32'h0));
    vecs.push_back(mk("C5", L, H, 3'b000, 32'h0,   26'h0,  32'h0, L, L, 32'h0,         L, H, 32'h104, L, 32'h0,   32'h0));
    vecs.push_back(mk("C6", L, H, 3'b000, 32'h0,   26'h0,  32'h0, L, H, 32'hA000_0100, L, H, 32'h104, L, 32'h0,   32'h0));
    vecs.push_back(mk("C7", L, H, 3'b000, 32'h0,   26'h0,  32'h0, L, L, 32'h0,         H, H, 32'h104, H, 32'h100, 32'hA000_0100));
    // Backward branch, then jump_reg winning over jump_target
    vecs.push_back(mk("D0", L, H, 3'b001, 32'h200, 26'h00FFFF, 32'h0,    H, L, 32'h0,         L, L, 32'h0,    L, 32'h0,    32'h0));
    vecs.push_back(mk("D1", L, H, 3'b000, 32'h0,   26'h0,      32'h0,    H, L, 32'h0,         L, H, 32'h200,  L, 32'h0,    32'h0));
    vecs.push_back(mk("D2", L, H, 3'b110, 32'h200, 26'h40,     32'h1000, H, L, 32'h0,         L, L, 32'h0,    L, 32'h0,    32'h0));
    vecs.push_back(mk("D3", L, H, 3'b000, 32'h0,   26'h0,      32'h0,    H, H, 32'hDEAD_0200, L, H, 32'h1000, L, 32'h0,    32'h0));
    vecs.push_back(mk("D4", L, H, 3'b000, 32'h0,   26'h0,      32'h0,    L, H, 32'hA000_1000, L, H, 32'h1004, L, 32'h0,    32'h0));
    vecs.push_back(mk("D5", L, H, 3'b000, 32'h0,   26'h0,      32'h0,    L, L, 32'h0,         H, H, 32'h1004, H, 32'h1000, 32'hA000_1000));
    // Redirect colliding with a response and a pop
    vecs.push_back(mk("E0", H, H, 3'b000, 32'h0,   26'h0, 32'h0, H, L, 32'h0,         L, H, 32'h0,   L, 32'h0,   32'h0));
    vecs.push_back(mk("E1", L, H, 3'b000, 32'h0,   26'h0, 32'h0, H, H, 32'hA000_0000, L, H, 32'h4,   L, 32'h0,   32'h0));
    vecs.push_back(mk("E2", L, H, 3'b000, 32'h0,   26'h0, 32'h0, H, L, 32'h0,         L, H, 32'h8,   H, 32'h0,   32'hA000_0000));
    vecs.push_back(mk("E3", L, H, 3'b001, 32'h300, 26'h1, 32'h0, H, H, 32'hA000_0004, H, L, 32'h0,   L, 32'h0,   32'h0));
    vecs.push_back(mk("E4", L, H, 3'b000, 32'h0,   26'h0, 32'h0, H, L, 32'h0,         H, H, 32'h308, L, 32'h0,   32'h0));
    vecs.push_back(mk("E5", L, H, 3'b000, 32'h0,   26'h0, 32'h0, L, H, 32'hDEAD_0004, H, L, 32'h0,   L, 32'h0,   32'h0));
    vecs.push_back(mk("E6", L, H, 3'b000, 32'h0,   26'h0, 32'h0, L, H, 32'hA000_0308, L, H, 32'h30C, L, 32'h0,   32'h0));
    vecs.push_back(mk("E7", L, H, 3'b000, 32'h0,   26'h0, 32'h0, L, L, 32'h0,         H, H, 32'h30C, H, 32'h308, 32'hA000_0308));
    // Fetch disabled: responses still land, nothing issues or pops
    vecs.push_back(mk("F0", L, L, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         H, L, 32'h0,   L, 32'h0,   32'h0));
    vecs.push_back(mk("F1", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         L, H, 32'h30C, L, 32'h0,   32'h0));
    vecs.push_back(mk("F2", L, L, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_030C, L, L, 32'h0,   L, 32'h0,   32'h0));
    vecs.push_back(mk("F3", L, L, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         H, L, 32'h0,   L, 32'h0,   32'h0));
    vecs.push_back(mk("F4", L, H, 3'b000, 32'h0, 26'h0, 32'h0, L, L, 32'h0,         H, H, 32'h310, H, 32'h30C, 32'hA000_030C));
    // Build up two filled slots and two outstanding requests before a mid-stream reset
    vecs.push_back(mk("G0", H, H, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         L, H, 32'h0, L, 32'h0, 32'h0));
    vecs.push_back(mk("G1", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_0000, L, H, 32'h4, L, 32'h0, 32'h0));
    vecs.push_back(mk("G2", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, H, 32'hA000_0004, L, H, 32'h8, H, 32'h0, 32'hA000_0000));
    vecs.push_back(mk("G3", L, H, 3'b000, 32'h0, 26'h0, 32'h0, H, L, 32'h0,         L, H, 32'hC, H, 32'h0, 32'hA000_0000));

    // Outputs held quiet under reset even with fetch enabled and both sides ready
    rst = 1'b0; en = 1'b1; reqReady = 1'b1; ifReady = 1'b1;
    #12;
    checkOutput("reset req_valid", 32'(reqValid), 32'h0);
    checkOutput("reset req_addr", reqAddr, 32'h0);
    checkOutput("reset if_valid", 32'(ifValid), 32'h0);
    checkOutput("reset if_pc", ifPc, 32'h0);
    checkOutput("reset if_instr", ifInstr, 32'h0);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Asynchronous reset between clock edges, right after G3 issued
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset req_valid", 32'(reqValid), 32'h0);
    checkOutput("midreset req_addr", reqAddr, 32'h0);
    checkOutput("midreset if_valid", 32'(ifValid), 32'h0);
    checkOutput("midreset if_pc", ifPc, 32'h0);
    checkOutput("midreset if_instr", ifInstr, 32'h0);
    @(negedge clk);
    rst = 1'b1; respValid = 1'b0; en = 1'b1; reqReady = 1'b1; ifReady = 1'b0;
    #1;
    checkOutput("postreset req_valid", 32'(reqValid), 32'h1);
    checkOutput("postreset req_addr", reqAddr, 32'h0);
    checkOutput("postreset if_valid", 32'(ifValid), 32'h0);
    @(negedge clk);
    driveIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
